// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: two one-entry holding registers share the register file write port.
// Drains oldest entry first; publishes a pending-write mask and a sticky protocol error flag.
module rf_wb_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_valid_i,
  input  logic [2:0]  a_reg_i,
  input  logic [15:0] a_data_i,
  output logic        a_ready_o,
  input  logic        b_valid_i,
  input  logic [2:0]  b_reg_i,
  input  logic [15:0] b_data_i,
  output logic        b_ready_o,
  output logic        write_o,
  output logic [2:0]  writeregsel_o,
  output logic [15:0] writedata_o,
  output logic [7:0]  pend_o,
  output logic        err_o
);

  logic        ha_v_q, ha_v_d;
  logic [2:0]  ha_reg_q, ha_reg_d;
  logic [15:0] ha_data_q, ha_data_d;
  logic        hb_v_q, hb_v_d;
  logic [2:0]  hb_reg_q, hb_reg_d;
  logic [15:0] hb_data_q, hb_data_d;
  logic        age_q, age_d;
  logic        tie_q, tie_d;
  logic        rr_q, rr_d;
  logic        a_stall_q, a_stall_d;
  logic        b_stall_q, b_stall_d;
  logic [2:0]  a_reg_prev_q, b_reg_prev_q;
  logic [15:0] a_data_prev_q, b_data_prev_q;
  logic        err_q, err_d;

  logic grant_a, grant_b;
  logic load_a, load_b;
  logic viol_a, viol_b;

  // Grants are gated by rst so entries discarded by reset never reach the register file.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst_i) begin
      if (ha_v_q && hb_v_q) begin
        if (tie_q) begin
          grant_a = ~rr_q;
          grant_b = rr_q;
        end else begin
          grant_a = age_q;
          grant_b = ~age_q;
        end
      end else begin
        grant_a = ha_v_q;
        grant_b = hb_v_q;
      end
    end
  end

  assign a_ready_o = ~ha_v_q | grant_a;
  assign b_ready_o = ~hb_v_q | grant_b;
  assign load_a    = a_valid_i & a_ready_o;
  assign load_b    = b_valid_i & b_ready_o;

  always_comb begin
    write_o       = grant_a | grant_b;
    writeregsel_o = 3'd0;
    writedata_o   = 16'd0;
    if (grant_a) begin
      writeregsel_o = ha_reg_q;
      writedata_o   = ha_data_q;
    end else if (grant_b) begin
      writeregsel_o = hb_reg_q;
      writedata_o   = hb_data_q;
    end
  end

  always_comb begin
    pend_o = 8'd0;
    if (ha_v_q) pend_o[ha_reg_q] = 1'b1;
    if (hb_v_q) pend_o[hb_reg_q] = 1'b1;
  end

  always_comb begin
    ha_v_d    = ha_v_q;
    ha_reg_d  = ha_reg_q;
    ha_data_d = ha_data_q;
    hb_v_d    = hb_v_q;
    hb_reg_d  = hb_reg_q;
    hb_data_d = hb_data_q;
    if (load_a) begin
      ha_v_d    = 1'b1;
      ha_reg_d  = a_reg_i;
      ha_data_d = a_data_i;
    end else if (grant_a) begin
      ha_v_d = 1'b0;
    end
    if (load_b) begin
      hb_v_d    = 1'b1;
      hb_reg_d  = b_reg_i;
      hb_data_d = b_data_i;
    end else if (grant_b) begin
      hb_v_d = 1'b0;
    end
  end

  // age: 1 = A older. A same-cycle capture on both sides is a tie resolved by rr.
  always_comb begin
    age_d = age_q;
    tie_d = tie_q;
    if (load_a && load_b) begin
      tie_d = 1'b1;
    end else if (load_a && hb_v_q && !grant_b) begin
      age_d = 1'b0;
      tie_d = 1'b0;
    end else if (load_b && ha_v_q && !grant_a) begin
      age_d = 1'b1;
      tie_d = 1'b0;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_a)      rr_d = 1'b1;
    else if (grant_b) rr_d = 1'b0;
  end

  assign a_stall_d = a_valid_i & ~a_ready_o;
  assign b_stall_d = b_valid_i & ~b_ready_o;
  assign viol_a = a_stall_q & (~a_valid_i | (a_reg_i != a_reg_prev_q) | (a_data_i != a_data_prev_q));
  assign viol_b = b_stall_q & (~b_valid_i | (b_reg_i != b_reg_prev_q) | (b_data_i != b_data_prev_q));
  assign err_d  = err_q | viol_a | viol_b;
  assign err_o  = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ha_v_q        <= 1'b0;
      ha_reg_q      <= 3'd0;
      ha_data_q     <= 16'd0;
      hb_v_q        <= 1'b0;
      hb_reg_q      <= 3'd0;
      hb_data_q     <= 16'd0;
      age_q         <= 1'b0;
      tie_q         <= 1'b0;
      rr_q          <= 1'b0;
      a_stall_q     <= 1'b0;
      b_stall_q     <= 1'b0;
      a_reg_prev_q  <= 3'd0;
      b_reg_prev_q  <= 3'd0;
      a_data_prev_q <= 16'd0;
      b_data_prev_q <= 16'd0;
      err_q         <= 1'b0;
    end else begin
      ha_v_q        <= ha_v_d;
      ha_reg_q      <= ha_reg_d;
      ha_data_q     <= ha_data_d;
      hb_v_q        <= hb_v_d;
      hb_reg_q      <= hb_reg_d;
      hb_data_q     <= hb_data_d;
      age_q         <= age_d;
      tie_q         <= tie_d;
      rr_q          <= rr_d;
      a_stall_q     <= a_stall_d;
      b_stall_q     <= b_stall_d;
      a_reg_prev_q  <= a_reg_i;
      b_reg_prev_q  <= b_reg_i;
      a_data_prev_q <= a_data_i;
      b_data_prev_q <= b_data_i;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter; inputs driven and outputs checked on the falling edge.
module tb_rf_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        a_valid_i = 1'b0;
  logic [2:0]  a_reg_i = 3'd0;
  logic [15:0] a_data_i = 16'd0;
  logic        a_ready_o;
  logic        b_valid_i = 1'b0;
  logic [2:0]  b_reg_i = 3'd0;
  logic [15:0] b_data_i = 16'd0;
  logic        b_ready_o;
  logic        write_o;
  logic [2:0]  writeregsel_o;
  logic [15:0] writedata_o;
  logic [7:0]  pend_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  logic [15:0] rf_m [8];

  rf_wb_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_valid_i(a_valid_i), .a_reg_i(a_reg_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
    .b_valid_i(b_valid_i), .b_reg_i(b_reg_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
    .write_o(write_o), .writeregsel_o(writeregsel_o), .writedata_o(writedata_o),
    .pend_o(pend_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Register-file model: captures whatever the arbiter drives at each rising edge.
  always @(posedge clk_i) begin
    if (write_o) begin
      rf_m[writeregsel_o] <= writedata_o;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int snap;
    int ga, gb, ia, ib;
    logic fa, fb;
    for (int i = 0; i < 8; i++) rf_m[i] = 16'd0;

    // reset state
    do_reset();
    check_eq("rst_a_ready", 32'(a_ready_o), 32'd1);
    check_eq("rst_b_ready", 32'(b_ready_o), 32'd1);
    check_eq("rst_write",   32'(write_o), 32'd0);
    check_eq("rst_sel",     32'(writeregsel_o), 32'd0);
    check_eq("rst_data",    32'(writedata_o), 32'd0);
    check_eq("rst_pend",    32'(pend_o), 32'd0);
    check_eq("rst_err",     32'(err_o), 32'd0);

    // A alone writes r3
    a_valid_i = 1'b1; a_reg_i = 3'd3; a_data_i = 16'h1234;
    check_eq("t1_a_ready", 32'(a_ready_o), 32'd1);
    @(negedge clk_i);
    a_valid_i = 1'b0;
    check_eq("t1_write", 32'(write_o), 32'd1);
    check_eq("t1_sel",   32'(writeregsel_o), 32'd3);
    check_eq("t1_data",  32'(writedata_o), 32'h1234);
    check_eq("t1_pend",  32'(pend_o), 32'h08);
    @(negedge clk_i);
    check_eq("t1_idle",  32'(write_o), 32'd0);
    check_eq("t1_pend0", 32'(pend_o), 32'h00);
    check_eq("t1_rf3",   32'(rf_m[3]), 32'h1234);

    // simultaneous A and B from reset: tie goes to A
    do_reset();
    a_valid_i = 1'b1; a_reg_i = 3'd1; a_data_i = 16'hAAAA;
    b_valid_i = 1'b1; b_reg_i = 3'd2; b_data_i = 16'hBBBB;
    @(negedge clk_i);
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    check_eq("t2_c1_sel",  32'(writeregsel_o), 32'd1);
    check_eq("t2_c1_data", 32'(writedata_o), 32'hAAAA);
    check_eq("t2_c1_bry",  32'(b_ready_o), 32'd0);
    check_eq("t2_c1_pend", 32'(pend_o), 32'h06);
    @(negedge clk_i);
    check_eq("t2_c2_sel",  32'(writeregsel_o), 32'd2);
    check_eq("t2_c2_data", 32'(writedata_o), 32'hBBBB);
    check_eq("t2_c2_pend", 32'(pend_o), 32'h04);
    @(negedge clk_i);
    check_eq("t2_c3_write", 32'(write_o), 32'd0);
    check_eq("t2_c3_pend",  32'(pend_o), 32'h00);
    check_eq("t2_rf1", 32'(rf_m[1]), 32'hAAAA);
    check_eq("t2_rf2", 32'(rf_m[2]), 32'hBBBB);

    // same-register ordering under contention: B's older r5 lands first
    do_reset();
    a_valid_i = 1'b1; a_reg_i = 3'd0; a_data_i = 16'h0A0A;
    b_valid_i = 1'b1; b_reg_i = 3'd5; b_data_i = 16'h0005;
    @(negedge clk_i);
    b_valid_i = 1'b0;
    a_reg_i = 3'd5; a_data_i = 16'h0050;
    check_eq("t3_c1_sel", 32'(writeregsel_o), 32'd0);
    check_eq("t3_c1_ary", 32'(a_ready_o), 32'd1);
    @(negedge clk_i);
    a_valid_i = 1'b0;
    check_eq("t3_c2_sel",  32'(writeregsel_o), 32'd5);
    check_eq("t3_c2_data", 32'(writedata_o), 32'h0005);
    @(negedge clk_i);
    check_eq("t3_c3_sel",  32'(writeregsel_o), 32'd5);
    check_eq("t3_c3_data", 32'(writedata_o), 32'h0050);
    @(negedge clk_i);
    check_eq("t3_idle", 32'(write_o), 32'd0);
    check_eq("t3_rf5",  32'(rf_m[5]), 32'h0050);

    // both sides streaming: grants alternate A, B
    do_reset();
    ga = 0; gb = 0; ia = 0; ib = 0; fa = 1'b0; fb = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (fa) ia++;
      if (fb) ib++;
      a_valid_i = 1'b1; a_reg_i = 3'(ia); a_data_i = 16'hA000 + 16'(ia);
      b_valid_i = 1'b1; b_reg_i = 3'(ib); b_data_i = 16'hB000 + 16'(ib);
      if (c > 0) begin
        check_eq($sformatf("t4_c%0d_write", c), 32'(write_o), 32'd1);
        if (c % 2 == 1)
          check_eq($sformatf("t4_c%0d_data", c), 32'(writedata_o), 32'(16'hA000 + 16'((c - 1) / 2)));
        else
          check_eq($sformatf("t4_c%0d_data", c), 32'(writedata_o), 32'(16'hB000 + 16'((c - 2) / 2)));
        check_eq($sformatf("t4_c%0d_ary", c), 32'(a_ready_o), 32'(c % 2));
        if (write_o && writedata_o[15:12] == 4'hA) ga++;
        if (write_o && writedata_o[15:12] == 4'hB) gb++;
      end
      if (c == 8) check_eq("t4_err", 32'(err_o), 32'd0);
      fa = a_ready_o; fb = b_ready_o;
      @(negedge clk_i);
    end
    check_eq("t4_grants_a", 32'(ga), 32'd4);
    check_eq("t4_grants_b", 32'(gb), 32'd4);

    // protocol violation: A stalled then drops valid
    do_reset();
    a_valid_i = 1'b1; a_reg_i = 3'd1; a_data_i = 16'h1111;
    b_valid_i = 1'b1; b_reg_i = 3'd2; b_data_i = 16'h2222;
    @(negedge clk_i);
    a_reg_i = 3'd3; a_data_i = 16'h3333;
    b_valid_i = 1'b0;
    @(negedge clk_i);
    a_reg_i = 3'd4; a_data_i = 16'h4444;
    check_eq("t5_c2_data", 32'(writedata_o), 32'h2222);
    check_eq("t5_c2_ary",  32'(a_ready_o), 32'd0);
    check_eq("t5_c2_err",  32'(err_o), 32'd0);
    @(negedge clk_i);
    a_valid_i = 1'b0;
    check_eq("t5_c3_err", 32'(err_o), 32'd0);
    @(negedge clk_i);
    check_eq("t5_err_set", 32'(err_o), 32'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    check_eq("t5_err_sticky", 32'(err_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_eq("t5_rst_err",  32'(err_o), 32'd0);
    check_eq("t5_rst_pend", 32'(pend_o), 32'h00);

    // reset with both holds valid discards them
    do_reset();
    snap = wr_cnt;
    a_valid_i = 1'b1; a_reg_i = 3'd6; a_data_i = 16'h6666;
    b_valid_i = 1'b1; b_reg_i = 3'd7; b_data_i = 16'h7777;
    @(negedge clk_i);
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    check_eq("t6_pend_full", 32'(pend_o), 32'hC0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_eq("t6_write", 32'(write_o), 32'd0);
    check_eq("t6_pend",  32'(pend_o), 32'h00);
    check_eq("t6_ary",   32'(a_ready_o), 32'd1);
    check_eq("t6_bry",   32'(b_ready_o), 32'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    check_eq("t6_no_writes", 32'(wr_cnt - snap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter that shares the register file's single write port between two requesters: the execute-stage result (A) and the memory-load result (B). Each requester has a one-entry holding register with a valid/ready handshake. The arbiter drains at most one entry per cycle into the 8 x 16-bit register file, oldest first. It also publishes a pending-write mask for hazard detection and flags handshake protocol violations.

## Interface
- No parameters: register file is fixed at 8 registers x 16 bits.
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset; sampled on rising edge of clk
- a_valid  input  1  requester A offers a write
- a_reg  input  3  requester A destination register
- a_data  input  16  requester A write data
- a_ready  output  1  requester A entry accepted this cycle when a_valid & a_ready
- b_valid, b_reg, b_data, b_ready  same widths and meaning for requester B
- write  output  1  write enable to register file
- writeregsel  output  3  destination register to register file
- writedata  output  16  data to register file
- pend  output  8  bit i = 1 when any holding register targets register i
- err  output  1  sticky protocol-violation flag

## Operation
- State:
  - hold_a: valid bit, reg, data.
  - hold_b: valid bit, reg, data.
  - age: 1 = A's entry is older; meaningful only when both holds are valid.
  - rr: tie pointer; 0 = A preferred, 1 = B preferred.
  - prev_a_stall, prev_b_stall, err.
- Grant (combinational, from hold state only):
  - Only one hold valid: grant it.
  - Both valid, captured in different cycles: grant the older one, per age.
  - Both valid, captured in the same cycle: grant the side rr points to.
  - Neither valid: no grant.
- Outputs:
  - write = grant_a | grant_b.
  - writeregsel and writedata come from the granted hold.
  - With no grant, writeregsel = 0 and writedata = 0.
- Ready: a_ready = ~hold_a.v | grant_a (pass-through refill allowed). b_ready is symmetric.
- Hold update per side, at the clock edge:
  - Accept (valid & ready): load the new entry; the hold stays valid.
  - Grant without accept: clear the hold.
  - Otherwise: hold unchanged.
- Age:
  - If exactly one side loads while the other hold stays valid and is not granted, the non-loading side becomes older.
  - If both sides load in the same cycle, mark a tie.
- rr: after any grant, point to the side not granted.
- pend: bitwise OR of onehot(hold_a.reg) if hold_a.v and onehot(hold_b.reg) if hold_b.v. Both holds may target the same register; pend shows one bit.
- Same-register ordering: entries for the same register reach the register file in capture order. A tie resolves per rr; both writes still occur, in separate cycles.
- Protocol check: prev_x_stall <= x_valid & ~x_ready.
  - If prev_x_stall is 1 and x_valid drops, or x_reg/x_data changed, set err.
  - err stays 1 until rst.
- A requester is never blocked for more than 1 cycle by the other: the oldest-first rule guarantees this.

## Timing
- Reset values:
  - a_ready = b_ready = 1.
  - write = 0, writeregsel = 0, writedata = 0.
  - pend = 0, err = 0.
  - Holds invalid, rr = 0, stall flags 0.
- rst during operation discards both holds; no write occurs in the reset cycle's outputs after the edge.
- Latency:
  - An entry accepted at edge N drives write during cycle N..N+1.
  - The register file captures it at edge N+1.
  - Uncontested throughput: 1 write per cycle per requester.
- Contention: with both sides streaming every cycle, grants alternate A, B, A, B. Each side's ready is high every other cycle.
- pend reflects hold state after each edge; a register's bit clears the edge its last pending write is granted.

## Test plan
- Reset, then A alone writes r3 = 0x1234 -> write = 1, writeregsel = 3, writedata = 0x1234 one cycle after accept; pend = 0x08 during that cycle, then 0x00.
- Simultaneous A(r1 = 0xAAAA), B(r2 = 0xBBBB) from reset -> cycle 1 writes r1 (rr = A), cycle 2 writes r2; b_ready = 0 in cycle 1; pend = 0x06 then 0x04 then 0x00.
- B holds r5 = 0x0005 while A arrives one cycle later with r5 = 0x0050 under continuous contention -> B written first, final r5 = 0x0050.
- Both sides valid for 8 cycles -> writes alternate A/B; each side gets exactly 4 grants.
- A stalled (a_ready = 0), then a_valid drops next cycle -> err = 1 and remains 1 until rst; rst returns err = 0 and pend = 0x00.
- rst asserted while both holds are valid -> after the edge write = 0, pend = 0, both ready = 1; neither discarded entry is ever written.
